// File: rtl/dataproc_core.sv
// Memory-mapped pixel transform: valid/ready sample stream in, per-mode transform,
// output FIFO drained by firmware through the DATA register.
module dataproc_core #(
    parameter logic [31:0] BASE_ADDR  = 32'h0200_1000,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        irq
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_THRESH = 3'd2;
    localparam logic [2:0] OFF_DATA   = 3'd3;
    localparam logic [2:0] OFF_PCOUNT = 3'd4;

    logic          en;
    logic          ie;
    logic [1:0]    mode;
    logic          flush_pending;
    logic [7:0]    thresh;
    logic [31:0]   pcount;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          stage_valid;
    logic [7:0]    stage_x;
    logic [7:0]    prev;

    logic          sel_c;
    logic          wr_c;
    logic          rd_c;
    logic [2:0]    off_c;
    logic          ctrl_wr_c;
    logic          pop_c;
    logic          push_c;
    logic          accept_c;
    logic [8:0]    sum_c;
    logic [7:0]    y_c;
    logic [31:0]   rdata_c;
    logic          unused_ok;

    assign unused_ok = ^{mem_addr[1:0], mem_wdata[31:8]};

    // Bus decode; a request is not re-selected in its own acknowledge cycle.
    assign sel_c     = mem_valid & ~mem_ready & (mem_addr[31:5] == BASE_ADDR[31:5]);
    assign wr_c      = sel_c & (|mem_wstrb);
    assign rd_c      = sel_c & ~(|mem_wstrb);
    assign off_c     = mem_addr[4:2];
    assign ctrl_wr_c = wr_c & (off_c == OFF_CTRL) & mem_wstrb[0];
    assign pop_c     = rd_c & (off_c == OFF_DATA) & (count != '0);
    assign push_c    = stage_valid & ~flush_pending;
    assign accept_c  = in_valid & in_ready;

    // Counting the stage reserves its FIFO slot, so an accepted sample can always land.
    assign in_ready = en & ~flush_pending &
                      (({1'b0, count} + (CW+1)'(stage_valid)) < (CW+1)'(FIFO_DEPTH));

    assign sum_c = {1'b0, stage_x} + {1'b0, prev};

    always_comb begin
        y_c = stage_x;
        case (mode)
            2'd1:    y_c = 8'hFF - stage_x;
            2'd2:    y_c = (stage_x >= thresh) ? 8'hFF : 8'h00;
            2'd3:    y_c = sum_c[8:1];
            default: y_c = stage_x;
        endcase
    end

    always_comb begin
        rdata_c = '0;
        case (off_c)
            OFF_CTRL:   rdata_c = {28'd0, ie, mode, en};
            OFF_STATUS: rdata_c = {16'd0, 8'(count), 6'd0,
                                   count == CW'(FIFO_DEPTH), count != '0};
            OFF_THRESH: rdata_c = {24'd0, thresh};
            OFF_DATA:   rdata_c = (count != '0) ? {24'd0, fifo_mem[rd_ptr]} : 32'd0;
            OFF_PCOUNT: rdata_c = pcount;
            default:    rdata_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_c) fifo_mem[wr_ptr] <= y_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_ready     <= 1'b0;
            mem_rdata     <= '0;
            irq           <= 1'b0;
            en            <= 1'b0;
            ie            <= 1'b0;
            mode          <= 2'd0;
            flush_pending <= 1'b0;
            thresh        <= 8'h80;
            pcount        <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            stage_valid   <= 1'b0;
            stage_x       <= '0;
            prev          <= '0;
        end else begin
            mem_ready     <= sel_c;
            mem_rdata     <= rd_c ? rdata_c : 32'd0;
            irq           <= ie & (count != '0);
            flush_pending <= ctrl_wr_c & mem_wdata[4];

            if (ctrl_wr_c) begin
                en   <= mem_wdata[0];
                mode <= mem_wdata[2:1];
                ie   <= mem_wdata[3];
            end
            if (wr_c && off_c == OFF_THRESH && mem_wstrb[0]) thresh <= mem_wdata[7:0];

            // in_ready is low while a flush is pending, so this also empties the stage.
            stage_valid <= accept_c;
            if (accept_c) stage_x <= in_data;

            if (flush_pending) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_c) wr_ptr <= wr_ptr + AW'(1);
                if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
                if (push_c && !pop_c)      count <= count + CW'(1);
                else if (!push_c && pop_c) count <= count - CW'(1);
            end

            if (flush_pending || (ctrl_wr_c && mem_wdata[0] && !en)) prev <= '0;
            else if (push_c && mode == 2'd3)                         prev <= stage_x;

            if (wr_c && off_c == OFF_PCOUNT) pcount <= '0;
            else if (push_c)                 pcount <= pcount + 32'd1;
        end
    end
endmodule

// File: tb/tb_dataproc_core.sv
// Directed self-checking bench for dataproc_core: bus, transforms, back-pressure,
// irq timing, concurrent stream/drain, flush and asynchronous reset.
module tb_dataproc_core;
    localparam logic [31:0] A_CTRL   = 32'h0200_1000;
    localparam logic [31:0] A_STATUS = 32'h0200_1004;
    localparam logic [31:0] A_THRESH = 32'h0200_1008;
    localparam logic [31:0] A_DATA   = 32'h0200_100C;
    localparam logic [31:0] A_PCOUNT = 32'h0200_1010;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        irq;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] rd;
    logic        irq_at_ack;
    int          acc;
    int          got;

    logic [7:0]  samp    [3]    = '{8'h10, 8'hF0, 8'h80};
    logic [7:0]  exp_tab [4][3] = '{'{8'h10, 8'hF0, 8'h80},
                                    '{8'hEF, 8'h0F, 8'h7F},
                                    '{8'h00, 8'hFF, 8'hFF},
                                    '{8'h08, 8'h80, 8'hB8}};

    dataproc_core #(.BASE_ADDR(32'h0200_1000), .FIFO_DEPTH(16)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One bus transfer; checks one-cycle latency and a single-cycle acknowledge.
    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, output logic [31:0] rdata);
        int lat;
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!mem_ready && lat < 8);
        rdata      = mem_rdata;
        irq_at_ack = irq;
        mem_valid  = 1'b0; mem_wstrb = 4'd0;
        chk("ack latency", 32'(lat), 32'd1);
        @(posedge clk); #1;
        chk("ack single pulse", 32'(mem_ready), 32'd0);
    endtask

    // Offer n incrementing samples; stops after n accepts or the cycle budget.
    task automatic stream(input logic [7:0] first, input int n, input int budget, output int accepted);
        logic hs;
        accepted = 0;
        in_data  = first;
        in_valid = (n > 0);
        for (int c = 0; c < budget && accepted < n; c++) begin
            @(negedge clk);
            hs = in_valid & in_ready;
            @(posedge clk); #1;
            if (hs) begin
                accepted++;
                in_data = in_data + 8'd1;
                if (accepted == n) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        in_valid = 1'b0; in_data = '0;
        #1;
        chk("reset mem_ready", 32'(mem_ready), 32'd0);
        chk("reset mem_rdata", mem_rdata, 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        chk("reset irq", 32'(irq), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        bus(A_CTRL,   0, 4'd0, rd); chk("reset CTRL", rd, 32'd0);
        bus(A_STATUS, 0, 4'd0, rd); chk("reset STATUS", rd, 32'd0);
        bus(A_THRESH, 0, 4'd0, rd); chk("reset THRESH", rd, 32'h80);
        bus(A_PCOUNT, 0, 4'd0, rd); chk("reset PCOUNT", rd, 32'd0);

        // Byte strobes without byte 0 leave CTRL alone.
        bus(A_CTRL, 32'h0F, 4'b0010, rd);
        bus(A_CTRL, 0, 4'd0, rd); chk("CTRL strobe ignored", rd, 32'd0);

        // Out-of-window request is never acknowledged.
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_addr = 32'h0200_2000; mem_wstrb = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("out-of-window no ack", 32'(mem_ready), 32'd0);
        mem_valid = 1'b0;

        // Each transform with a flush before it.
        for (int m = 0; m < 4; m++) begin
            bus(A_CTRL, 32'(32'h11 | (m << 1)), 4'h1, rd);
            for (int i = 0; i < 3; i++) begin
                stream(samp[i], 1, 10, acc);
                chk("mode accept", 32'(acc), 32'd1);
            end
            for (int i = 0; i < 3; i++) begin
                bus(A_DATA, 0, 4'd0, rd);
                chk($sformatf("mode%0d data%0d", m, i), rd, {24'd0, exp_tab[m][i]});
            end
        end

        // Fill to full, then resume after draining four.
        bus(A_CTRL, 32'h11, 4'h1, rd);
        bus(A_PCOUNT, 32'hFFFF_FFFF, 4'hF, rd);
        bus(A_PCOUNT, 0, 4'd0, rd); chk("PCOUNT cleared", rd, 32'd0);
        stream(8'h00, 20, 30, acc);
        chk("full accepts", 32'(acc), 32'd16);
        chk("full in_ready", 32'(in_ready), 32'd0);
        bus(A_STATUS, 0, 4'd0, rd); chk("full STATUS", rd, 32'h1003);
        for (int i = 0; i < 4; i++) begin
            bus(A_DATA, 0, 4'd0, rd); chk("full pop", rd, 32'(i));
        end
        stream(8'h10, 4, 20, acc);
        chk("resume accepts", 32'(acc), 32'd4);
        for (int i = 4; i < 20; i++) begin
            bus(A_DATA, 0, 4'd0, rd); chk("full drain", rd, 32'(i));
        end
        bus(A_PCOUNT, 0, 4'd0, rd); chk("PCOUNT 20", rd, 32'd20);

        // Empty read, then irq timing.
        bus(A_DATA, 0, 4'd0, rd);   chk("empty DATA", rd, 32'd0);
        bus(A_STATUS, 0, 4'd0, rd); chk("empty count", rd, 32'd0);
        bus(A_CTRL, 32'h09, 4'h1, rd);
        in_valid = 1'b1; in_data = 8'h55;
        @(negedge clk);
        chk("irq in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("irq accept+0", 32'(irq), 32'd0);
        @(posedge clk); #1;
        chk("irq accept+1", 32'(irq), 32'd0);
        @(posedge clk); #1;
        chk("irq accept+2", 32'(irq), 32'd1);
        bus(A_DATA, 0, 4'd0, rd);
        chk("irq data", rd, 32'h55);
        chk("irq held at ack", 32'(irq_at_ack), 32'd1);
        chk("irq cleared", 32'(irq), 32'd0);

        // Continuous stream while polling DATA.
        bus(A_CTRL, 32'h11, 4'h1, rd);
        got = 0;
        fork
            stream(8'h40, 24, 400, acc);
            begin
                for (int r = 0; r < 120 && got < 24; r++) begin
                    bus(A_DATA, 0, 4'd0, rd);
                    if (rd != 32'd0) begin
                        chk("concurrent data", rd, 32'(32'h40 + got));
                        got++;
                    end
                end
            end
        join
        chk("concurrent accepts", 32'(acc), 32'd24);
        chk("concurrent popped", 32'(got), 32'd24);
        bus(A_STATUS, 0, 4'd0, rd); chk("concurrent STATUS", rd, 32'd0);

        // Flush with the stage occupied, in average mode.
        bus(A_CTRL, 32'h07, 4'h1, rd);
        in_valid = 1'b1; in_data = 8'hA0;
        bus(A_CTRL, 32'h17, 4'h1, rd);
        in_valid = 1'b0;
        bus(A_STATUS, 0, 4'd0, rd); chk("flush STATUS", rd, 32'd0);
        stream(8'h60, 1, 10, acc);
        bus(A_DATA, 0, 4'd0, rd); chk("flush prev cleared", rd, 32'h30);

        // Asynchronous reset with five entries queued and an acknowledge in flight.
        bus(A_CTRL, 32'h11, 4'h1, rd);
        bus(A_THRESH, 32'h33, 4'h1, rd);
        stream(8'h01, 5, 20, acc);
        chk("pre-reset accepts", 32'(acc), 32'd5);
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_addr = A_STATUS; mem_wstrb = 4'd0;
        @(posedge clk); #1;
        chk("pre-reset ack", 32'(mem_ready), 32'd1);
        chk("pre-reset STATUS", mem_rdata, 32'h0501);
        chk("pre-reset in_ready", 32'(in_ready), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset mem_ready", 32'(mem_ready), 32'd0);
        chk("async reset mem_rdata", mem_rdata, 32'd0);
        chk("async reset in_ready", 32'(in_ready), 32'd0);
        chk("async reset irq", 32'(irq), 32'd0);
        mem_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        bus(A_STATUS, 0, 4'd0, rd); chk("post-reset STATUS", rd, 32'd0);
        bus(A_PCOUNT, 0, 4'd0, rd); chk("post-reset PCOUNT", rd, 32'd0);
        bus(A_THRESH, 0, 4'd0, rd); chk("post-reset THRESH", rd, 32'h80);
        bus(A_CTRL, 0, 4'd0, rd);   chk("post-reset CTRL", rd, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
